// File: rtl/mmio_out_pkg.sv
// mmio_out_pkg
// Shared definitions for the memory-mapped output bank on the 0x1000_7xxx I/O page:
// register offsets within a channel slot, the CTRL slot index, store-width encodings,
// CTRL bit positions and the read-modify-write operation applied to a shadow register.
package mmio_out_pkg;

  localparam logic [1:0] OFF_DATA = 2'd0;
  localparam logic [1:0] OFF_SET  = 2'd1;
  localparam logic [1:0] OFF_CLR  = 2'd2;
  localparam logic [1:0] OFF_TGL  = 2'd3;

  localparam logic [3:0] CTRL_IDX = 4'hF;

  typedef enum logic [2:0] {
    ST_B = 3'b000,
    ST_H = 3'b001,
    ST_W = 3'b010
  } st_funct3_e;

  localparam int CTRL_DB_EN_BIT  = 0;
  localparam int CTRL_COMMIT_BIT = 1;

  // New register value for a store to offset 'off'; only lanes in 'mask' are affected.
  function automatic logic [31:0] apply_op(input logic [1:0]  off,
                                           input logic [31:0] cur,
                                           input logic [31:0] mask,
                                           input logic [31:0] data);
    logic [31:0] dm;
    dm = data & mask;
    case (off)
      OFF_SET: apply_op = cur | dm;
      OFF_CLR: apply_op = cur & ~dm;
      OFF_TGL: apply_op = cur ^ dm;
      default: apply_op = (cur & ~mask) | dm;
    endcase
  endfunction

endpackage

// File: rtl/mmio_store_align.sv
// mmio_store_align
// Combinational store alignment: turns a store width and the low address bits into a
// byte-lane mask and lane-aligned data, and flags misaligned or unknown-width stores.
// Ports:
//   i_funct3     store width (SB/SH/SW)
//   i_addr_lo    address bits [1:0]
//   i_data       right-aligned store data
//   o_mask       byte-lane mask (32 bits, byte granular)
//   o_data       data shifted into the selected lanes
//   o_misalign   SH on an odd address or SW not word aligned
//   o_bad_funct3 width encoding is not SB/SH/SW
module mmio_store_align
  import mmio_out_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [31:0] o_mask,
  output logic [31:0] o_data,
  output logic        o_misalign,
  output logic        o_bad_funct3
);

  logic [4:0] shamt;
  assign shamt = {i_addr_lo, 3'b000};

  always_comb begin
    o_mask       = 32'h0;
    o_data       = 32'h0;
    o_misalign   = 1'b0;
    o_bad_funct3 = 1'b0;
    case (i_funct3)
      ST_B: begin
        o_mask = 32'h0000_00FF << shamt;
        o_data = {24'h0, i_data[7:0]} << shamt;
      end
      ST_H: begin
        o_misalign = i_addr_lo[0];
        if (i_addr_lo[1]) begin
          o_mask = 32'hFFFF_0000;
          o_data = {i_data[15:0], 16'h0};
        end else begin
          o_mask = 32'h0000_FFFF;
          o_data = {16'h0, i_data[15:0]};
        end
      end
      ST_W: begin
        o_misalign = |i_addr_lo;
        o_mask     = 32'hFFFF_FFFF;
        o_data     = i_data;
      end
      default: o_bad_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/mmio_output_bank.sv
// mmio_output_bank
// Output register bank with NUM_CH 32-bit channels. Each channel has a shadow and a
// live register; stores go to the shadow via DATA/SET/CLR/TGL aliases. In direct mode
// live follows the shadow on the same edge; in double-buffer mode live only updates
// on a commit (or when db_en drops from 1 to 0).
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_io_addr            byte address, bits [7:0] decoded (idx = [7:4], reg = [3:2])
//   i_st_data, i_funct3  store data and width
//   i_io_wren, i_io_rden store / load strobes
//   o_ld_data, o_rvalid  registered load data and valid pulse
//   o_err                access error pulse
//   o_ch_data            live registers, channel k at [32k+31:32k]
//   o_ch_upd             per-channel pulse when the live value changed
module mmio_output_bank
  import mmio_out_pkg::*;
#(
  parameter int          NUM_CH    = 5,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [31:0]           i_io_addr,
  input  logic [31:0]           i_st_data,
  input  logic [2:0]            i_funct3,
  input  logic                  i_io_wren,
  input  logic                  i_io_rden,
  output logic [31:0]           o_ld_data,
  output logic                  o_rvalid,
  output logic                  o_err,
  output logic [NUM_CH*32-1:0]  o_ch_data,
  output logic [NUM_CH-1:0]     o_ch_upd
);

  localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);

  logic [3:0]  idx;
  logic [1:0]  off;
  logic        unused_addr_hi;
  logic [31:0] al_mask, al_data;
  logic        al_misalign, al_bad_f3;
  logic        is_ch, is_ctrl, mapped;
  logic        st_err, st_ok, ld_err;

  assign idx            = i_io_addr[7:4];
  assign off            = i_io_addr[3:2];
  assign unused_addr_hi = ^i_io_addr[31:8];

  mmio_store_align u_align (
    .i_funct3     (i_funct3),
    .i_addr_lo    (i_io_addr[1:0]),
    .i_data       (i_st_data),
    .o_mask       (al_mask),
    .o_data       (al_data),
    .o_misalign   (al_misalign),
    .o_bad_funct3 (al_bad_f3)
  );

  // Only the DATA offset of the CTRL slot is mapped.
  assign is_ch   = ({1'b0, idx} < NUM_CH_W);
  assign is_ctrl = (idx == CTRL_IDX) && (off == OFF_DATA);
  assign mapped  = is_ch | is_ctrl;

  assign st_err = i_io_wren & (al_misalign | al_bad_f3 | ~mapped);
  assign st_ok  = i_io_wren & ~st_err;
  assign ld_err = i_io_rden & ~mapped;

  logic [31:0]       shadow_q [NUM_CH];
  logic [31:0]       shadow_d [NUM_CH];
  logic [31:0]       live_q   [NUM_CH];
  logic [31:0]       live_d   [NUM_CH];
  logic              db_en_q, db_en_d, commit;
  logic [NUM_CH-1:0] upd_q, upd_d;
  logic [31:0]       ld_q, ld_d;
  logic              rvalid_q, err_q;

  always_comb begin
    shadow_d = shadow_q;
    live_d   = live_q;
    db_en_d  = db_en_q;
    commit   = 1'b0;
    upd_d    = '0;
    // CTRL lives in byte lane 0; a store that does not cover it leaves CTRL alone.
    if (st_ok && is_ctrl && al_mask[0]) begin
      db_en_d = al_data[CTRL_DB_EN_BIT];
      commit  = al_data[CTRL_COMMIT_BIT] | (db_en_q & ~al_data[CTRL_DB_EN_BIT]);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (st_ok && is_ch && (idx == 4'(k))) begin
        shadow_d[k] = apply_op(off, shadow_q[k], al_mask, al_data);
        if (!db_en_q) live_d[k] = shadow_d[k];
      end
      // A commit is always a CTRL store, so no channel store competes with it.
      if (commit) live_d[k] = shadow_q[k];
      upd_d[k] = (live_d[k] != live_q[k]);
    end
  end

  // Load mux samples pre-store state so a same-edge store is not visible.
  always_comb begin
    ld_d = 32'h0;
    if (is_ctrl) begin
      ld_d[CTRL_DB_EN_BIT] = db_en_q;
    end else if (is_ch) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (idx == 4'(k)) ld_d = (off == OFF_DATA) ? shadow_q[k] : live_q[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_q[k] <= RESET_VAL;
        live_q[k]   <= RESET_VAL;
      end
      db_en_q  <= 1'b0;
      upd_q    <= '0;
      ld_q     <= 32'h0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      live_q   <= live_d;
      db_en_q  <= db_en_d;
      upd_q    <= upd_d;
      if (i_io_rden) ld_q <= ld_d;
      rvalid_q <= i_io_rden;
      err_q    <= st_err | ld_err;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_out
    assign o_ch_data[32*k +: 32] = live_q[k];
  end

  assign o_ld_data = ld_q;
  assign o_rvalid  = rvalid_q;
  assign o_err     = err_q;
  assign o_ch_upd  = upd_q;

endmodule

// File: tb/tb_mmio_output_bank.sv
// tb_mmio_output_bank
// Directed scenarios for mmio_output_bank (NUM_CH = 5). Every access pushes its expected
// outcome into a scoreboard queue; the observed outputs of the following cycle are
// queued alongside and each scenario task drains and compares both queues.
module tb_mmio_output_bank;

  localparam int NCH = 5;
  localparam int CW  = NCH * 32;

  logic           i_clk = 1'b0;
  logic           i_reset = 1'b0;
  logic [31:0]    i_io_addr = 32'h0;
  logic [31:0]    i_st_data = 32'h0;
  logic [2:0]     i_funct3 = 3'b010;
  logic           i_io_wren = 1'b0;
  logic           i_io_rden = 1'b0;
  logic [31:0]    o_ld_data;
  logic           o_rvalid;
  logic           o_err;
  logic [CW-1:0]  o_ch_data;
  logic [NCH-1:0] o_ch_upd;

  mmio_output_bank #(.NUM_CH(NCH), .RESET_VAL(32'h0)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_io_addr (i_io_addr),
    .i_st_data (i_st_data),
    .i_funct3  (i_funct3),
    .i_io_wren (i_io_wren),
    .i_io_rden (i_io_rden),
    .o_ld_data (o_ld_data),
    .o_rvalid  (o_rvalid),
    .o_err     (o_err),
    .o_ch_data (o_ch_data),
    .o_ch_upd  (o_ch_upd)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          rst;
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
  } stim_t;

  typedef struct {
    string       name;
    bit          rv;
    bit          chk_ld;
    logic [31:0] ld;
    bit          err;
    logic [4:0]  upd;
    int          ch;
    logic [31:0] chv;
  } exp_t;

  typedef struct {
    logic          rv;
    logic [31:0]   ld;
    logic          err;
    logic [4:0]    upd;
    logic [CW-1:0] chd;
  } obs_t;

  exp_t sbq[$];
  obs_t obq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  function automatic stim_t S(input bit rst, input bit wr, input bit rd,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [2:0] f3);
    stim_t s;
    s.rst = rst; s.wr = wr; s.rd = rd; s.addr = addr; s.data = data; s.f3 = f3;
    return s;
  endfunction

  function automatic exp_t E(input string n, input bit rv, input bit chk_ld,
                             input logic [31:0] ld, input bit err, input logic [4:0] upd,
                             input int ch, input logic [31:0] chv);
    exp_t e;
    e.name = n; e.rv = rv; e.chk_ld = chk_ld; e.ld = ld; e.err = err; e.upd = upd;
    e.ch = ch; e.chv = chv;
    return e;
  endfunction

  // Called at a falling edge: drives one cycle, lets the rising edge accept it and
  // records the outputs at the next falling edge (middle of cycle N+1).
  task automatic drive(input stim_t s, input exp_t e);
    obs_t o;
    sbq.push_back(e);
    i_reset   = s.rst;
    i_io_wren = s.wr;
    i_io_rden = s.rd;
    i_io_addr = s.addr;
    i_st_data = s.data;
    i_funct3  = s.f3;
    @(negedge i_clk);
    i_reset   = 1'b0;
    i_io_wren = 1'b0;
    i_io_rden = 1'b0;
    o.rv  = o_rvalid;
    o.ld  = o_ld_data;
    o.err = o_err;
    o.upd = o_ch_upd;
    o.chd = o_ch_data;
    obq.push_back(o);
  endtask

  task automatic test_reset_sw();
    exp_t e;
    obs_t o;
    drive(S(1, 0, 0, 32'h0, 32'h0, SW), E("reset", 0, 1, 32'h0, 0, 5'b00000, 0, 32'h0));
    n_cmp++;
    if (o_ch_data !== '0) begin
      n_bad++; $display("FAIL reset_ch_data got %h exp 0", o_ch_data);
    end
    drive(S(0, 1, 0, 32'h1000_7000, 32'hDEAD_BEEF, SW), E("sw_ch0", 0, 0, 0, 0, 5'b00001, 0, 32'hDEAD_BEEF));
    drive(S(0, 0, 0, 32'h0, 32'h0, SW),                 E("sw_ch0_pulse_end", 0, 0, 0, 0, 5'b00000, 0, 32'hDEAD_BEEF));
    drive(S(0, 1, 0, 32'h1000_7000, 32'hDEAD_BEEF, SW), E("sw_ch0_same", 0, 0, 0, 0, 5'b00000, 0, 32'hDEAD_BEEF));
    drive(S(0, 0, 1, 32'h1000_7000, 32'h0, SW),         E("ld_ch0", 1, 1, 32'hDEAD_BEEF, 0, 5'b00000, 0, 32'hDEAD_BEEF));
    drive(S(0, 0, 0, 32'h0, 32'h0, SW),                 E("ld_ch0_rvalid_end", 0, 0, 0, 0, 5'b00000, 0, 32'hDEAD_BEEF));
    while (sbq.size() > 0 && obq.size() > 0) begin
      e = sbq.pop_front(); o = obq.pop_front();
      n_cmp++; if (o.rv !== e.rv) begin n_bad++; $display("FAIL %s rvalid got %b exp %b", e.name, o.rv, e.rv); end
      n_cmp++; if (o.err !== e.err) begin n_bad++; $display("FAIL %s err got %b exp %b", e.name, o.err, e.err); end
      n_cmp++; if (o.upd !== e.upd) begin n_bad++; $display("FAIL %s upd got %b exp %b", e.name, o.upd, e.upd); end
      n_cmp++; if (o.chd[32*e.ch +: 32] !== e.chv) begin n_bad++; $display("FAIL %s ch%0d got %h exp %h", e.name, e.ch, o.chd[32*e.ch +: 32], e.chv); end
      if (e.chk_ld) begin
        n_cmp++; if (o.ld !== e.ld) begin n_bad++; $display("FAIL %s ld_data got %h exp %h", e.name, o.ld, e.ld); end
      end
    end
  endtask

  task automatic test_partial();
    exp_t e;
    obs_t o;
    drive(S(0, 1, 0, 32'h1000_7013, 32'h0000_00AB, SB), E("sb_ch1_b3", 0, 0, 0, 0, 5'b00010, 1, 32'hAB00_0000));
    drive(S(0, 1, 0, 32'h1000_7022, 32'h0000_1234, SH), E("sh_ch2_hi", 0, 0, 0, 0, 5'b00100, 2, 32'h1234_0000));
    drive(S(0, 1, 0, 32'h1000_7011, 32'hFFFF_FF55, SB), E("sb_ch1_b1", 0, 0, 0, 0, 5'b00010, 1, 32'hAB00_5500));
    drive(S(0, 1, 0, 32'h1000_7020, 32'hFFFF_5678, SH), E("sh_ch2_lo", 0, 0, 0, 0, 5'b00100, 2, 32'h1234_5678));
    drive(S(0, 0, 1, 32'h1000_7010, 32'h0, SB),         E("ld_ch1", 1, 1, 32'hAB00_5500, 0, 5'b00000, 1, 32'hAB00_5500));
    while (sbq.size() > 0 && obq.size() > 0) begin
      e = sbq.pop_front(); o = obq.pop_front();
      n_cmp++; if (o.rv !== e.rv) begin n_bad++; $display("FAIL %s rvalid got %b exp %b", e.name, o.rv, e.rv); end
      n_cmp++; if (o.err !== e.err) begin n_bad++; $display("FAIL %s err got %b exp %b", e.name, o.err, e.err); end
      n_cmp++; if (o.upd !== e.upd) begin n_bad++; $display("FAIL %s upd got %b exp %b", e.name, o.upd, e.upd); end
      n_cmp++; if (o.chd[32*e.ch +: 32] !== e.chv) begin n_bad++; $display("FAIL %s ch%0d got %h exp %h", e.name, e.ch, o.chd[32*e.ch +: 32], e.chv); end
      if (e.chk_ld) begin
        n_cmp++; if (o.ld !== e.ld) begin n_bad++; $display("FAIL %s ld_data got %h exp %h", e.name, o.ld, e.ld); end
      end
    end
  endtask

  task automatic test_atomic();
    exp_t e;
    obs_t o;
    drive(S(0, 1, 0, 32'h1000_7030, 32'h0F0F_0F0F, SW), E("ch3_init", 0, 0, 0, 0, 5'b01000, 3, 32'h0F0F_0F0F));
    drive(S(0, 1, 0, 32'h1000_7034, 32'hF000_0000, SW), E("ch3_set", 0, 0, 0, 0, 5'b01000, 3, 32'hFF0F_0F0F));
    drive(S(0, 1, 0, 32'h1000_7038, 32'h0000_000F, SW), E("ch3_clr", 0, 0, 0, 0, 5'b01000, 3, 32'hFF0F_0F00));
    drive(S(0, 1, 0, 32'h1000_703C, 32'hFFFF_FFFF, SW), E("ch3_tgl", 0, 0, 0, 0, 5'b01000, 3, 32'h00F0_F0FF));
    drive(S(0, 1, 0, 32'h1000_7034, 32'h0000_0000, SW), E("ch3_set_zero", 0, 0, 0, 0, 5'b00000, 3, 32'h00F0_F0FF));
    drive(S(0, 0, 1, 32'h1000_7034, 32'h0, SW),         E("ld_ch3_live", 1, 1, 32'h00F0_F0FF, 0, 5'b00000, 3, 32'h00F0_F0FF));
    drive(S(0, 1, 0, 32'h1000_703D, 32'h0000_00FF, SB), E("ch3_tgl_b1", 0, 0, 0, 0, 5'b01000, 3, 32'h00F0_0FFF));
    drive(S(0, 0, 1, 32'h1000_7030, 32'h0, SW),         E("ld_ch3_shadow", 1, 1, 32'h00F0_0FFF, 0, 5'b00000, 3, 32'h00F0_0FFF));
    while (sbq.size() > 0 && obq.size() > 0) begin
      e = sbq.pop_front(); o = obq.pop_front();
      n_cmp++; if (o.rv !== e.rv) begin n_bad++; $display("FAIL %s rvalid got %b exp %b", e.name, o.rv, e.rv); end
      n_cmp++; if (o.err !== e.err) begin n_bad++; $display("FAIL %s err got %b exp %b", e.name, o.err, e.err); end
      n_cmp++; if (o.upd !== e.upd) begin n_bad++; $display("FAIL %s upd got %b exp %b", e.name, o.upd, e.upd); end
      n_cmp++; if (o.chd[32*e.ch +: 32] !== e.chv) begin n_bad++; $display("FAIL %s ch%0d got %h exp %h", e.name, e.ch, o.chd[32*e.ch +: 32], e.chv); end
      if (e.chk_ld) begin
        n_cmp++; if (o.ld !== e.ld) begin n_bad++; $display("FAIL %s ld_data got %h exp %h", e.name, o.ld, e.ld); end
      end
    end
  endtask

  task automatic test_double_buffer();
    exp_t e;
    obs_t o;
    drive(S(0, 1, 0, 32'h1000_70F0, 32'h1, SW),         E("db_on", 0, 0, 0, 0, 5'b00000, 0, 32'hDEAD_BEEF));
    drive(S(0, 0, 1, 32'h1000_70F0, 32'h0, SW),         E("ld_ctrl_db1", 1, 1, 32'h1, 0, 5'b00000, 0, 32'hDEAD_BEEF));
    drive(S(0, 1, 0, 32'h1000_7000, 32'h11, SW),        E("db_st_ch0", 0, 0, 0, 0, 5'b00000, 0, 32'hDEAD_BEEF));
    drive(S(0, 1, 0, 32'h1000_7010, 32'h22, SW),        E("db_st_ch1", 0, 0, 0, 0, 5'b00000, 1, 32'hAB00_5500));
    drive(S(0, 0, 1, 32'h1000_7000, 32'h0, SW),         E("db_ld_shadow", 1, 1, 32'h11, 0, 5'b00000, 0, 32'hDEAD_BEEF));
    drive(S(0, 0, 1, 32'h1000_7004, 32'h0, SW),         E("db_ld_live", 1, 1, 32'hDEAD_BEEF, 0, 5'b00000, 0, 32'hDEAD_BEEF));
    drive(S(0, 1, 0, 32'h1000_70F0, 32'h3, SW),         E("db_commit", 0, 0, 0, 0, 5'b00011, 0, 32'h11));
    drive(S(0, 0, 0, 32'h0, 32'h0, SW),                 E("db_commit_end", 0, 0, 0, 0, 5'b00000, 1, 32'h22));
    drive(S(0, 0, 1, 32'h1000_70F0, 32'h0, SW),         E("ld_ctrl_commit_rd0", 1, 1, 32'h1, 0, 5'b00000, 1, 32'h22));
    drive(S(0, 1, 0, 32'h1000_70F1, 32'h0, SB),         E("ctrl_sb_lane1", 0, 0, 0, 0, 5'b00000, 1, 32'h22));
    drive(S(0, 0, 1, 32'h1000_70F0, 32'h0, SW),         E("ld_ctrl_kept", 1, 1, 32'h1, 0, 5'b00000, 1, 32'h22));
    drive(S(0, 1, 0, 32'h1000_7040, 32'h5, SW),         E("db_st_ch4", 0, 0, 0, 0, 5'b00000, 4, 32'h0));
    drive(S(0, 1, 0, 32'h1000_70F0, 32'h0, SW),         E("db_off_commit", 0, 0, 0, 0, 5'b10000, 4, 32'h5));
    drive(S(0, 0, 1, 32'h1000_70F0, 32'h0, SW),         E("ld_ctrl_db0", 1, 1, 32'h0, 0, 5'b00000, 4, 32'h5));
    drive(S(0, 1, 0, 32'h1000_7040, 32'h6, SW),         E("direct_ch4", 0, 0, 0, 0, 5'b10000, 4, 32'h6));
    while (sbq.size() > 0 && obq.size() > 0) begin
      e = sbq.pop_front(); o = obq.pop_front();
      n_cmp++; if (o.rv !== e.rv) begin n_bad++; $display("FAIL %s rvalid got %b exp %b", e.name, o.rv, e.rv); end
      n_cmp++; if (o.err !== e.err) begin n_bad++; $display("FAIL %s err got %b exp %b", e.name, o.err, e.err); end
      n_cmp++; if (o.upd !== e.upd) begin n_bad++; $display("FAIL %s upd got %b exp %b", e.name, o.upd, e.upd); end
      n_cmp++; if (o.chd[32*e.ch +: 32] !== e.chv) begin n_bad++; $display("FAIL %s ch%0d got %h exp %h", e.name, e.ch, o.chd[32*e.ch +: 32], e.chv); end
      if (e.chk_ld) begin
        n_cmp++; if (o.ld !== e.ld) begin n_bad++; $display("FAIL %s ld_data got %h exp %h", e.name, o.ld, e.ld); end
      end
    end
  endtask

  task automatic test_errors();
    exp_t e;
    obs_t o;
    drive(S(0, 1, 0, 32'h1000_7002, 32'hFFFF_FFFF, SW), E("err_sw_misalign", 0, 0, 0, 1, 5'b00000, 0, 32'h11));
    drive(S(0, 0, 0, 32'h0, 32'h0, SW),                 E("err_pulse_end", 0, 0, 0, 0, 5'b00000, 0, 32'h11));
    drive(S(0, 1, 0, 32'h1000_7000, 32'hFF, 3'b011),    E("err_funct3", 0, 0, 0, 1, 5'b00000, 0, 32'h11));
    drive(S(0, 1, 0, 32'h1000_7001, 32'hFF, SH),        E("err_sh_odd", 0, 0, 0, 1, 5'b00000, 0, 32'h11));
    drive(S(0, 1, 0, 32'h1000_7050, 32'hFF, SW),        E("err_st_unmapped", 0, 0, 0, 1, 5'b00000, 4, 32'h6));
    drive(S(0, 1, 0, 32'h1000_70F4, 32'h1, SW),         E("err_st_ctrl_set", 0, 0, 0, 1, 5'b00000, 0, 32'h11));
    drive(S(0, 0, 1, 32'h1000_70F0, 32'h0, SW),         E("ld_ctrl_unchanged", 1, 1, 32'h0, 0, 5'b00000, 0, 32'h11));
    drive(S(0, 0, 1, 32'h1000_7050, 32'h0, SW),         E("err_ld_unmapped", 1, 1, 32'h0, 1, 5'b00000, 0, 32'h11));
    drive(S(0, 0, 1, 32'h1000_70F8, 32'h0, SW),         E("err_ld_ctrl_clr", 1, 1, 32'h0, 1, 5'b00000, 0, 32'h11));
    drive(S(0, 0, 1, 32'h1000_7000, 32'h0, 3'b011),     E("ld_funct3_ignored", 1, 1, 32'h11, 0, 5'b00000, 0, 32'h11));
    drive(S(0, 0, 1, 32'h1000_7002, 32'h0, SW),         E("ld_align_ignored", 1, 1, 32'h11, 0, 5'b00000, 0, 32'h11));
    drive(S(0, 1, 1, 32'h1000_7000, 32'h99, SW),        E("st_ld_same_edge", 1, 1, 32'h11, 0, 5'b00001, 0, 32'h99));
    while (sbq.size() > 0 && obq.size() > 0) begin
      e = sbq.pop_front(); o = obq.pop_front();
      n_cmp++; if (o.rv !== e.rv) begin n_bad++; $display("FAIL %s rvalid got %b exp %b", e.name, o.rv, e.rv); end
      n_cmp++; if (o.err !== e.err) begin n_bad++; $display("FAIL %s err got %b exp %b", e.name, o.err, e.err); end
      n_cmp++; if (o.upd !== e.upd) begin n_bad++; $display("FAIL %s upd got %b exp %b", e.name, o.upd, e.upd); end
      n_cmp++; if (o.chd[32*e.ch +: 32] !== e.chv) begin n_bad++; $display("FAIL %s ch%0d got %h exp %h", e.name, e.ch, o.chd[32*e.ch +: 32], e.chv); end
      if (e.chk_ld) begin
        n_cmp++; if (o.ld !== e.ld) begin n_bad++; $display("FAIL %s ld_data got %h exp %h", e.name, o.ld, e.ld); end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    obs_t o;
    drive(S(0, 1, 0, 32'h1000_70F0, 32'h1, SW),         E("mid_db_on", 0, 0, 0, 0, 5'b00000, 2, 32'h1234_5678));
    drive(S(0, 1, 0, 32'h1000_7020, 32'hCAFE, SW),      E("mid_pending", 0, 0, 0, 0, 5'b00000, 2, 32'h1234_5678));
    drive(S(1, 1, 0, 32'h1000_7030, 32'h77, SW),        E("mid_reset", 0, 1, 32'h0, 0, 5'b00000, 3, 32'h0));
    n_cmp++;
    if (o_ch_data !== '0) begin
      n_bad++; $display("FAIL mid_reset_ch_data got %h exp 0", o_ch_data);
    end
    drive(S(0, 0, 1, 32'h1000_7020, 32'h0, SW),         E("mid_ld_shadow2", 1, 1, 32'h0, 0, 5'b00000, 2, 32'h0));
    drive(S(0, 0, 1, 32'h1000_7030, 32'h0, SW),         E("mid_ld_shadow3", 1, 1, 32'h0, 0, 5'b00000, 3, 32'h0));
    drive(S(0, 0, 1, 32'h1000_70F0, 32'h0, SW),         E("mid_ld_ctrl", 1, 1, 32'h0, 0, 5'b00000, 0, 32'h0));
    drive(S(0, 1, 0, 32'h1000_7000, 32'h1, SW),         E("mid_direct", 0, 0, 0, 0, 5'b00001, 0, 32'h1));
    while (sbq.size() > 0 && obq.size() > 0) begin
      e = sbq.pop_front(); o = obq.pop_front();
      n_cmp++; if (o.rv !== e.rv) begin n_bad++; $display("FAIL %s rvalid got %b exp %b", e.name, o.rv, e.rv); end
      n_cmp++; if (o.err !== e.err) begin n_bad++; $display("FAIL %s err got %b exp %b", e.name, o.err, e.err); end
      n_cmp++; if (o.upd !== e.upd) begin n_bad++; $display("FAIL %s upd got %b exp %b", e.name, o.upd, e.upd); end
      n_cmp++; if (o.chd[32*e.ch +: 32] !== e.chv) begin n_bad++; $display("FAIL %s ch%0d got %h exp %h", e.name, e.ch, o.chd[32*e.ch +: 32], e.chv); end
      if (e.chk_ld) begin
        n_cmp++; if (o.ld !== e.ld) begin n_bad++; $display("FAIL %s ld_data got %h exp %h", e.name, o.ld, e.ld); end
      end
    end
  endtask

  initial begin
    @(negedge i_clk);
    test_reset_sw();
    test_partial();
    test_atomic();
    test_double_buffer();
    test_errors();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
